prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 31 +++
 rtl/prog_loader.sv | 140 ++++++++++++++
 tb/tb_prog_loader.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared CPU load-bus definitions (opcodes, bus widths, loader state codes) and the loader package.
// Optional feature macro used by prog_loader: PROG_LOADER_CKSUM_EN.
`ifndef PROG_LOADER_DEFINITIONS
`define PROG_LOADER_DEFINITIONS
`define ON        1'b1
`define OFF       1'b0
`define BIT_INST  15:0
`define BIT_DATA  15:0
`define LD_INS    4'hA
`define SZA_INS   16
`define PL_IDLE   3'd0
`define PL_WAIT   3'd1
`define PL_ADDR   3'd2
`define PL_DATA   3'd3
`define PL_END    3'd4
`define PL_FIN    3'd5
`endif

package prog_loader_pkg;
    localparam int CNT_W  = 4;
    localparam int ADDR_W = 4;

    typedef enum logic [2:0] {
        S_IDLE = `PL_IDLE,
        S_WAIT = `PL_WAIT,
        S_ADDR = `PL_ADDR,
        S_DATA = `PL_DATA,
        S_END  = `PL_END,
        S_FIN  = `PL_FIN
    } pl_state_t;
endpackage

// File: rtl/prog_loader.sv
// Streams host words into the CPU instruction memory over the io_inst/io_din load bus.
// Define PROG_LOADER_CKSUM_EN to add a running modulo-2^16 checksum output (cksum).
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int HOLD_CYC = 2,
    parameter int N_INS    = `SZA_INS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             host_valid,
    input  logic [`BIT_DATA] host_data,
    input  logic             host_last,
    output logic             host_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             interrupt,
    output logic [`BIT_INST] io_inst,
    output logic [`BIT_DATA] io_din
`ifdef PROG_LOADER_CKSUM_EN
    ,
    output logic [`BIT_DATA] cksum
`endif
);

    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_INS - 1);

    pl_state_t           state;
    logic [CNT_W-1:0]    hold_cnt;
    logic [ADDR_W-1:0]   addr;
    logic [`BIT_DATA]    word_q;
    logic                last_q;
    logic                hold_end;
    logic                at_top;

    assign hold_end = (hold_cnt == HOLD_LAST);
    assign at_top   = (addr == ADDR_LAST);

    // Outputs are loaded on the transition into each state so every one is a plain register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            hold_cnt   <= '0;
            addr       <= '0;
            word_q     <= '0;
            last_q     <= 1'b0;
            host_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            interrupt  <= `OFF;
            io_inst    <= '0;
            io_din     <= '0;
`ifdef PROG_LOADER_CKSUM_EN
            cksum      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_WAIT;
                        busy       <= 1'b1;
                        host_ready <= 1'b1;
                        interrupt  <= `ON;
                        err        <= 1'b0;
                        addr       <= '0;
`ifdef PROG_LOADER_CKSUM_EN
                        cksum      <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (host_valid && host_ready) begin
                        state      <= S_ADDR;
                        host_ready <= 1'b0;
                        word_q     <= host_data;
                        // The top slot always closes the session; a missing last flag there is an overflow.
                        last_q     <= host_last || at_top;
                        if (at_top && !host_last)
                            err <= 1'b1;
                        io_inst    <= {`LD_INS, addr, 8'h00};
                        io_din     <= '0;
`ifdef PROG_LOADER_CKSUM_EN
                        cksum      <= cksum + host_data;
`endif
                    end
                end
                S_ADDR: begin
                    if (hold_end) begin
                        state    <= S_DATA;
                        hold_cnt <= '0;
                        io_din   <= word_q;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (hold_end) begin
                        hold_cnt <= '0;
                        if (last_q) begin
                            state   <= S_END;
                            io_inst <= '1;
                            io_din  <= '0;
                        end else begin
                            state      <= S_WAIT;
                            host_ready <= 1'b1;
                            addr       <= addr + 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_END: begin
                    if (hold_end) begin
                        state     <= S_FIN;
                        hold_cnt  <= '0;
                        interrupt <= `OFF;
                        io_inst   <= '0;
                        io_din    <= '0;
                        done      <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: bus phases are compared as (inst, din, length, done) segments.
module tb_prog_loader;
    localparam int         HOLD = 2;
    localparam int         NINS = 4;
    localparam logic [3:0] LD   = 4'hA;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        host_valid = 1'b0;
    logic [15:0] host_data = 16'h0;
    logic        host_last = 1'b0;
    logic        host_ready, busy, done, err, interrupt;
    logic [15:0] io_inst, io_din;
`ifdef PROG_LOADER_CKSUM_EN
    logic [15:0] cksum;
`endif

    prog_loader #(.HOLD_CYC(HOLD), .N_INS(NINS)) dut (
        .clock(clock), .reset(reset), .start(start),
        .host_valid(host_valid), .host_data(host_data), .host_last(host_last),
        .host_ready(host_ready), .busy(busy), .done(done), .err(err),
        .interrupt(interrupt), .io_inst(io_inst), .io_din(io_din)
`ifdef PROG_LOADER_CKSUM_EN
        , .cksum(cksum)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] inst;
        logic [15:0] din;
        int          len;
        logic        dn;
    } seg_t;

    seg_t        exp_q[$];
    int          n_checks = 0;
    int          n_errs = 0;
    logic [3:0]  m_addr = 4'd0;
    logic [15:0] m_sum = 16'h0;
    logic        m_err = 1'b0;
    bit          mon_off = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Segment tuple: {host_ready, interrupt, done, io_inst, io_din}
    task automatic emit(input logic [34:0] s, input int len);
        seg_t e;
        if (mon_off) return;
        if (s[34]) begin
            check_val("wait_irq", s[33], 1);
            return;
        end
        if (!s[33] && !s[32]) return;
        if (exp_q.size() == 0) begin
            check_val("sb_extra_seg", 32'(exp_q.size()), 1);
            return;
        end
        e = exp_q.pop_front();
        check_val("seg_inst", s[31:16], e.inst);
        check_val("seg_din", s[15:0], e.din);
        check_val("seg_len", len, e.len);
        check_val("seg_done", s[32], e.dn);
    endtask

    initial begin
        logic [34:0] cur_t;
        logic [34:0] t;
        int          run;
        cur_t = 'x;
        run = 0;
        forever begin
            @(negedge clock);
            t = {host_ready, interrupt, done, io_inst, io_din};
            if (t !== cur_t) begin
                if (run > 0) emit(cur_t, run);
                cur_t = t;
                run = 1;
            end else begin
                run++;
            end
        end
    end

    task automatic start_session();
        @(negedge clock);
        start = 1'b1;
        m_addr = 4'd0;
        m_sum = 16'h0;
        m_err = 1'b0;
        @(negedge clock);
        start = 1'b0;
        check_val("start_busy", busy, 1);
        check_val("start_ready", host_ready, 1);
        check_val("start_err_clr", err, 0);
    endtask

    task automatic send_word(input logic [15:0] w, input logic lst);
        bit         acc;
        logic       eff;
        logic [15:0] inst;
        acc = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (i == 0) begin
                host_valid = 1'b1;
                host_data = w;
                host_last = lst;
            end
            if (host_ready) begin
                acc = 1'b1;
                break;
            end
        end
        check_val("accept", acc, 1);
        if (acc) begin
            eff = lst || (m_addr == 4'(NINS - 1));
            if (!lst && m_addr == 4'(NINS - 1)) m_err = 1'b1;
            m_sum = m_sum + w;
            inst = {LD, m_addr, 8'h00};
            exp_q.push_back('{inst, 16'h0000, HOLD, 1'b0});
            exp_q.push_back('{inst, w, HOLD, 1'b0});
            if (eff) begin
                exp_q.push_back('{16'hFFFF, 16'h0000, HOLD, 1'b0});
                exp_q.push_back('{16'h0000, 16'h0000, 1, 1'b1});
            end else begin
                m_addr = m_addr + 4'd1;
            end
            @(posedge clock);
        end
        #1;
        host_valid = 1'b0;
        host_last = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_val({tag, "_done"}, seen, 1);
        if (seen) begin
            check_val({tag, "_err"}, err, m_err);
            check_val({tag, "_irq"}, interrupt, 0);
`ifdef PROG_LOADER_CKSUM_EN
            check_val({tag, "_cksum"}, cksum, m_sum);
`endif
            @(negedge clock);
            check_val({tag, "_pulse"}, done, 0);
            check_val({tag, "_idle"}, busy, 0);
            @(negedge clock);
            check_val({tag, "_sb_drain"}, exp_q.size(), 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        bit          dseen;
        logic        errv;
        logic        dn;

        repeat (3) @(negedge clock);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_ready", host_ready, 0);
        check_val("rst_irq", interrupt, 0);
        check_val("rst_inst", io_inst, 0);
        check_val("rst_din", io_din, 0);
        reset = 1'b0;

        // single word
        start_session();
        send_word(16'h0A0A, 1'b1);
        wait_done("single");

        // three words with a host_valid gap
        start_session();
        send_word(16'h1111, 1'b0);
        repeat (9) @(negedge clock);
        check_val("gap_ready", host_ready, 1);
        check_val("gap_irq", interrupt, 1);
        check_val("gap_busy", busy, 1);
        send_word(16'h1212, 1'b0);
        send_word(16'h1313, 1'b1);
        wait_done("three");

        // overflow: N_INS words without last, then a fifth offered
        start_session();
        for (int i = 0; i < NINS; i++) send_word(16'h2000 + 16'(i), 1'b0);
        acc = 1'b0;
        dseen = 1'b0;
        errv = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (i == 0) begin
                host_valid = 1'b1;
                host_data = 16'h2005;
            end
            if (host_ready) acc = 1'b1;
            if (done) begin
                dseen = 1'b1;
                errv = err;
            end
        end
        host_valid = 1'b0;
        check_val("ovf_no_accept", acc, 0);
        check_val("ovf_done", dseen, 1);
        check_val("ovf_err", errv, 1);
        check_val("ovf_err_sticky", err, 1);
        check_val("ovf_sb_drain", exp_q.size(), 0);
        start_session();
        send_word(16'h2100, 1'b1);
        wait_done("after_ovf");

        // reset in DATA of word 1
        start_session();
        send_word(16'h3232, 1'b0);
        send_word(16'h3333, 1'b0);
        repeat (3) @(negedge clock);
        check_val("pre_rst_din", io_din, 16'h3333);
        mon_off = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        check_val("abort_err", err, 0);
        check_val("abort_ready", host_ready, 0);
        check_val("abort_irq", interrupt, 0);
        check_val("abort_inst", io_inst, 0);
        check_val("abort_din", io_din, 0);
        dn = 1'b0;
        repeat (4) begin
            @(negedge clock);
            dn = dn | done;
        end
        check_val("abort_no_done", dn, 0);
        exp_q.delete();
        mon_off = 1'b0;
        start_session();
        send_word(16'h3434, 1'b1);
        wait_done("reload");

        // start pulses while busy
        start_session();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check_val("busy_start_ready", host_ready, 1);
        send_word(16'h5555, 1'b0);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check_val("busy_start_inst", io_inst, {LD, 4'd0, 8'h00});
        send_word(16'h6666, 1'b1);
        wait_done("busy_start");

`ifdef PROG_LOADER_CKSUM_EN
        start_session();
        send_word(16'hFFFF, 1'b0);
        send_word(16'h0002, 1'b1);
        wait_done("cksum");
        check_val("cksum_wrap", cksum, 16'h0001);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
